// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: pops bytes from the uart_fifo read port and sends each one LSB first as a UART frame on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit(s).

module uart_fifo_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int RD_LATENCY = 1
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  fifo_rempty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  tx_en,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(DATA_WIDTH + STOP_BITS) + 1;
    localparam int FETCH_W      = 2;

    localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0]  BAUD_PRE   = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]   DATA_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]   STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic [FETCH_W-1:0] FETCH_LAST = FETCH_W'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_e;

    state_e                  state_q, state_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [FETCH_W-1:0]      fetch_q, fetch_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    tx_busy_q, tx_busy_d;
    logic                    tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    logic pop;
    logic baud_last;

    // The pop strobe is decoded in the IDLE cycle itself so the FIFO sees it at the same edge
    // that moves us to FETCH; gating with rrst_n keeps it quiet while reset is held.
    always_comb begin
        pop       = rrst_n && (state_q == ST_IDLE) && tx_en && !fifo_rempty;
        baud_last = (baud_q == BAUD_LAST);
    end

    always_comb begin
        // NOTE: every _d takes its hold value first so no branch can leave one unassigned (no latch).
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        fetch_d   = fetch_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    state_d = ST_FETCH;
                    fetch_d = '0;
                end
            end

            ST_FETCH: begin
                if (fetch_q == FETCH_LAST) begin
                    shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_rdata;
`endif
                    state_d = ST_START;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                end else begin
                    fetch_d = fetch_q + FETCH_W'(1);
                end
            end

            ST_START: begin
                if (baud_last) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            ST_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last) begin
                    state_d = ST_STOP;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif

            ST_STOP: begin
                // Raised one cycle early so the registered pulse lands on the final stop cycle.
                tx_done_d = (bit_q == STOP_LAST) && (baud_q == BAUD_PRE);
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        tx_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            // NOTE: datapath registers are reset with the control state so nothing downstream sees X.
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            fetch_q   <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            fetch_q   <= fetch_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            tx_busy_q <= tx_busy_d;
            tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign fifo_r_en = pop;
    assign tx        = tx_q;
    assign tx_busy   = tx_busy_q;
    assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: directed and random stimulus for uart_fifo_tx, checked every cycle against a
// frame-timeline model, with literal expectations for the documented waveforms and gaps.

module tb_uart_fifo_tx;

    localparam int CPB = 10;
    localparam int RL  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int          FRAME     = 11;
    localparam int          FRAME_CLK = 110;
    localparam logic [15:0] A5_BITS   = 16'hFD4A;
`else
    localparam int          FRAME     = 10;
    localparam int          FRAME_CLK = 100;
    localparam logic [15:0] A5_BITS   = 16'hFF4A;
`endif

    logic       clk = 1'b0;
    logic       rrst_n;
    logic       fifo_rempty;
    logic       fifo_r_en;
    logic [7:0] fifo_rdata;
    logic       tx_en;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int errors    = 0;
    int checks    = 0;
    int pop_count = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] lat_data[RL];
    bit         lat_vld[RL];
    bit         pop_seen = 1'b0;

    bit          m_active = 1'b0;
    int          m_t = 0;
    logic [15:0] m_bits = '1;

    uart_fifo_tx #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (100_000),
        .DATA_WIDTH(8),
        .STOP_BITS (1),
        .RD_LATENCY(RL)
    ) dut (
        .rclk       (clk),
        .rrst_n     (rrst_n),
        .fifo_rempty(fifo_rempty),
        .fifo_r_en  (fifo_r_en),
        .fifo_rdata (fifo_rdata),
        .tx_en      (tx_en),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] frame_of(input logic [7:0] b);
        logic [15:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_bytes.push_back(b);
    endtask

    // FIFO read-port model: pop seen mid-cycle, data and empty flag update just after the next edge.
    always @(negedge clk) begin
        pop_seen = (fifo_r_en === 1'b1);
        if (pop_seen) pop_count++;
    end

    always @(posedge clk) begin
        #1;
        for (int i = RL - 1; i > 0; i--) begin
            lat_data[i] = lat_data[i-1];
            lat_vld[i]  = lat_vld[i-1];
        end
        lat_vld[0]  = 1'b0;
        lat_data[0] = 8'($urandom);
        if (pop_seen && fifo_q.size() > 0) begin
            lat_data[0] = fifo_q.pop_front();
            lat_vld[0]  = 1'b1;
        end
        pop_seen    = 1'b0;
        fifo_rdata  = lat_vld[RL-1] ? lat_data[RL-1] : 8'($urandom);
        fifo_rempty = (fifo_q.size() == 0);
    end

    // Timeline model: t=0 pop cycle, t=1..RL fetch, then FRAME bits of CPB cycles each.
    always @(negedge clk) begin : model
        logic exp_pop, exp_tx, exp_busy, exp_done;
        int   j;
        exp_pop  = 1'b0;
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (!m_active) begin
            if (rrst_n && tx_en && !fifo_rempty) begin
                exp_pop  = 1'b1;
                m_bits   = (exp_bytes.size() > 0) ? frame_of(exp_bytes.pop_front()) : '1;
                m_active = 1'b1;
                m_t      = 0;
            end
        end else begin
            exp_busy = 1'b1;
            if (m_t > RL) begin
                j        = m_t - RL - 1;
                exp_tx   = m_bits[j / CPB];
                exp_done = (j == FRAME * CPB - 1);
            end
            if (exp_done) m_active = 1'b0;
        end
        m_t++;
        if (!rrst_n) m_active = 1'b0;
        check("cycle {r_en,tx,busy,done}", {28'd0, fifo_r_en, tx, tx_busy, tx_done},
              {28'd0, exp_pop, exp_tx, exp_busy, exp_done});
    end

    // Waits for a start bit, samples mid-bit, and returns frame length (start..done) and idle gap.
    task automatic capture_frame(output logic [15:0] bits, output int cycles, output int gap,
                                 output bit ok);
        bits   = '1;
        cycles = 0;
        gap    = 0;
        ok     = 1'b1;
        @(negedge clk);
        while (tx !== 1'b0) begin
            gap++;
            if (gap > 3000) begin
                ok = 1'b0;
                return;
            end
            @(negedge clk);
        end
        cycles = 1;
        forever begin
            if (((cycles - 1) % CPB == CPB / 2) && ((cycles - 1) / CPB < 16))
                bits[(cycles-1)/CPB] = tx;
            if (tx_done === 1'b1) break;
            if (cycles > 3000) begin
                ok = 1'b0;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic wait_level(input bit want_tx_low, output bit ok);
        int w;
        w  = 0;
        ok = 1'b1;
        do begin
            @(negedge clk);
            w++;
            if (w > 3000) begin
                ok = 1'b0;
                return;
            end
        end while (want_tx_low ? (tx !== 1'b0) : (tx_done !== 1'b1));
    endtask

    initial begin : main
        logic [15:0] bits;
        logic [7:0]  exp3[3];
        int          cyc, gap, base, w;
        bit          ok, all_high;

        rrst_n      = 1'b0;
        tx_en       = 1'b1;
        fifo_rempty = 1'b1;
        fifo_rdata  = '0;
        push(8'hA5);

        // Reset held with a non-empty FIFO: line idle, no pop.
        repeat (3) begin
            @(negedge clk);
            check("reset_tx", {31'd0, tx}, 32'd1);
            check("reset_r_en", {31'd0, fifo_r_en}, 32'd0);
            check("reset_busy", {31'd0, tx_busy}, 32'd0);
            check("reset_done", {31'd0, tx_done}, 32'd0);
        end
        check("reset_no_pop", pop_count, 0);
        @(posedge clk);
        #2 rrst_n = 1'b1;

        // Single byte 0xA5.
        capture_frame(bits, cyc, gap, ok);
        check("a5_found", {31'd0, ok}, 32'd1);
        check("a5_bits", {16'd0, bits}, {16'd0, A5_BITS});
        check("a5_frame_len", cyc, FRAME_CLK);
        check("a5_pops", pop_count, 1);
        @(negedge clk);
        check("a5_done_pulse", {31'd0, tx_done}, 32'd0);
        check("a5_busy_end", {31'd0, tx_busy}, 32'd0);

        // Back-to-back frames.
        @(posedge clk);
        #2;
        base = pop_count;
        exp3 = '{8'h00, 8'hFF, 8'h55};
        for (int i = 0; i < 3; i++) push(exp3[i]);
        for (int i = 0; i < 3; i++) begin
            capture_frame(bits, cyc, gap, ok);
            check("b2b_found", {31'd0, ok}, 32'd1);
            check("b2b_byte", {24'd0, bits[8:1]}, {24'd0, exp3[i]});
            check("b2b_len", cyc, FRAME_CLK);
            if (i > 0) check("b2b_gap", gap, 1 + RL);
        end
        check("b2b_pops", pop_count - base, 3);

        // tx_en dropped mid-frame.
        @(posedge clk);
        #2;
        base = pop_count;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_level(1'b1, ok);
        check("txen_start_seen", {31'd0, ok}, 32'd1);
        repeat (50) @(posedge clk);
        #2 tx_en = 1'b0;
        wait_level(1'b0, ok);
        check("txen_done_seen", {31'd0, ok}, 32'd1);
        all_high = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1) all_high = 1'b0;
        end
        check("txen_line_high", {31'd0, all_high}, 32'd1);
        check("txen_busy_low", {31'd0, tx_busy}, 32'd0);
        check("txen_one_pop", pop_count - base, 1);
        @(posedge clk);
        #2 tx_en = 1'b1;
        capture_frame(bits, cyc, gap, ok);
        check("txen_resume_1", {24'd0, bits[8:1]}, 32'h22);
        capture_frame(bits, cyc, gap, ok);
        check("txen_resume_2", {24'd0, bits[8:1]}, 32'h33);

        // Reset during data bit 4.
        @(posedge clk);
        #2;
        base = pop_count;
        push(8'h96);
        push(8'h3C);
        wait_level(1'b1, ok);
        check("rst_start_seen", {31'd0, ok}, 32'd1);
        repeat (55) @(negedge clk);
        @(posedge clk);
        #2 rrst_n = 1'b0;
        @(posedge clk);
        #2 rrst_n = 1'b1;
        @(negedge clk);
        check("rst_tx_high", {31'd0, tx}, 32'd1);
        check("rst_busy_low", {31'd0, tx_busy}, 32'd0);
        capture_frame(bits, cyc, gap, ok);
        check("rst_next_byte", {24'd0, bits[8:1]}, 32'h3C);
        check("rst_next_len", cyc, FRAME_CLK);
        check("rst_no_repop", pop_count - base, 2);

`ifdef UART_TX_PARITY_EN
        // Even parity.
        @(posedge clk);
        #2;
        push(8'h07);
        capture_frame(bits, cyc, gap, ok);
        check("par07_bit", {31'd0, bits[9]}, 32'd1);
        check("par07_len", cyc, 110);
        push(8'h03);
        capture_frame(bits, cyc, gap, ok);
        check("par03_bit", {31'd0, bits[9]}, 32'd0);
`endif

        // Random traffic with tx_en toggling and occasional resets.
        for (int c = 0; c < 15000; c++) begin
            @(posedge clk);
            #2;
            rrst_n = ($urandom_range(0, 2499) != 0);
            if ($urandom_range(0, 29) == 0 && fifo_q.size() < 6) push(8'($urandom));
            if ($urandom_range(0, 399) == 0) tx_en = ~tx_en;
        end
        @(posedge clk);
        #2;
        rrst_n = 1'b1;
        tx_en  = 1'b1;
        w = 0;
        while ((fifo_q.size() > 0 || tx_busy !== 1'b0 || fifo_r_en !== 1'b0) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("drain_in_time", {31'd0, (w < 5000)}, 32'd1);
        repeat (3) @(negedge clk);
        check("drain_idle", {30'd0, tx_busy, tx}, 32'd1);
        check("drain_pop_agree", exp_bytes.size(), fifo_q.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
